// File: rtl/sipo_frame_rx.sv
// Framed serial receiver: start bit, DATA_W data bits LSB-first, optional even parity, stop bit.
// Parity support is compiled in with the SIPO_RX_PARITY_EN macro.
module sipo_frame_rx #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              serial_in,
  input  logic              bit_en,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              busy,
  output logic              frame_err,
  output logic              parity_err,
  output logic              overrun
);

  localparam int CNT_W = $clog2(DATA_W + 1);

`ifdef SIPO_RX_PARITY_EN
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
`endif

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [DATA_W-1:0]   shreg_reg, shreg_next;
  logic [DATA_W-1:0]   data_out_reg, data_out_next;
  logic                data_valid_reg, data_valid_next;
  logic                frame_err_reg, frame_err_next;
  logic                parity_err_reg, parity_err_next;
  logic                overrun_reg, overrun_next;
  logic                par_bad;

`ifdef SIPO_RX_PARITY_EN
  logic                par_bad_reg, par_bad_next;
  assign par_bad = par_bad_reg;
`else
  assign par_bad = 1'b0;
`endif

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    shreg_next      = shreg_reg;
    data_out_next   = data_out_reg;
    // Handshake runs every cycle, independent of bit_en.
    data_valid_next = data_valid_reg & ~data_ready;
    frame_err_next  = 1'b0;
    parity_err_next = 1'b0;
    overrun_next    = 1'b0;
`ifdef SIPO_RX_PARITY_EN
    par_bad_next    = par_bad_reg;
`endif
    if (bit_en) begin
      case (state_reg)
        IDLE: begin
          if (!serial_in) begin
            state_next = DATA;
            cnt_next   = '0;
          end
        end
        DATA: begin
          shreg_next = {serial_in, shreg_reg[DATA_W-1:1]};
          cnt_next   = cnt_reg + CNT_W'(1);
          if (cnt_reg == CNT_W'(DATA_W - 1)) begin
`ifdef SIPO_RX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end
`ifdef SIPO_RX_PARITY_EN
        PARITY: begin
          // Even parity: XOR over data and parity bit must be 0.
          par_bad_next = ^{shreg_reg, serial_in};
          state_next   = STOP;
        end
`endif
        STOP: begin
          state_next = IDLE;
          if (!serial_in) begin
            frame_err_next = 1'b1;
          end else if (par_bad) begin
            parity_err_next = 1'b1;
          end else if (!data_valid_reg || data_ready) begin
            data_out_next   = shreg_reg;
            data_valid_next = 1'b1;
          end else begin
            overrun_next = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      shreg_reg      <= '0;
      data_out_reg   <= '0;
      data_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      parity_err_reg <= 1'b0;
      overrun_reg    <= 1'b0;
`ifdef SIPO_RX_PARITY_EN
      par_bad_reg    <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      shreg_reg      <= shreg_next;
      data_out_reg   <= data_out_next;
      data_valid_reg <= data_valid_next;
      frame_err_reg  <= frame_err_next;
      parity_err_reg <= parity_err_next;
      overrun_reg    <= overrun_next;
`ifdef SIPO_RX_PARITY_EN
      par_bad_reg    <= par_bad_next;
`endif
    end
  end

  assign data_out   = data_out_reg;
  assign data_valid = data_valid_reg;
  assign busy       = (state_reg != IDLE);
  assign frame_err  = frame_err_reg;
  assign parity_err = parity_err_reg;
  assign overrun    = overrun_reg;

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Directed plus randomized frames against a frame-level model of the receiver's
// delivery, error and handshake rules.
module tb_sipo_frame_rx;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              serial_in;
  logic              bit_en;
  logic              data_ready;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              busy;
  logic              frame_err;
  logic              parity_err;
  logic              overrun;

  int checks = 0;
  int errors = 0;

  // Model: the word the consumer should currently see and whether it is pending.
  logic              model_valid;
  logic [DATA_W-1:0] model_data;

  always #5 clk = ~clk;

  sipo_frame_rx #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .serial_in(serial_in), .bit_en(bit_en),
    .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
    .busy(busy), .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; an edge with data_ready high consumes the pending word.
  task automatic step();
    @(posedge clk); #1;
    if (data_ready) model_valid = 1'b0;
  endtask

  task automatic strobe(input logic b, input int gap);
    serial_in = b;
    bit_en    = 1'b1;
    step();
    bit_en    = 1'b0;
    serial_in = 1'b1;
    repeat (gap - 1) step();
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] d, input logic stop_b, input logic par_ok,
                            input logic rdy, input int gap, input string tag);
    logic pok, good, exp_ov;
`ifdef SIPO_RX_PARITY_EN
    pok = par_ok;
`else
    pok = 1'b1;
`endif
    strobe(1'b0, gap);
    check({tag, ":busy_mid"}, 32'(busy), 32'd1);
    for (int i = 0; i < DATA_W; i++) strobe(d[i], gap);
`ifdef SIPO_RX_PARITY_EN
    strobe((^d) ^ ~par_ok, gap);
`endif
    serial_in  = stop_b;
    bit_en     = 1'b1;
    data_ready = rdy;
    @(posedge clk); #1;
    good   = stop_b && pok;
    exp_ov = 1'b0;
    if (good) begin
      if (!model_valid || rdy) begin
        model_valid = 1'b1;
        model_data  = d;
      end else begin
        exp_ov = 1'b1;
      end
    end else if (rdy) begin
      model_valid = 1'b0;
    end
    $display("frame %s data=%02h stop=%0b pok=%0b rdy=%0b -> valid=%0b out=%02h fe=%0b pe=%0b ov=%0b",
             tag, d, stop_b, pok, rdy, data_valid, data_out, frame_err, parity_err, overrun);
    check({tag, ":frame_err"},  32'(frame_err),  32'(!stop_b));
    check({tag, ":parity_err"}, 32'(parity_err), 32'(stop_b && !pok));
    check({tag, ":overrun"},    32'(overrun),    32'(exp_ov));
    check({tag, ":data_valid"}, 32'(data_valid), 32'(model_valid));
    check({tag, ":data_out"},   32'(data_out),   32'(model_data));
    check({tag, ":busy_end"},   32'(busy),       32'd0);
    bit_en    = 1'b0;
    serial_in = 1'b1;
  endtask

  task automatic pulse_clear(input string tag);
    step();
    check({tag, ":pulses_clear"}, 32'({frame_err, parity_err, overrun}), 32'd0);
  endtask

  initial begin
    logic [DATA_W-1:0] rd;
    rst = 1'b1; serial_in = 1'b1; bit_en = 1'b0; data_ready = 1'b0;
    model_valid = 1'b0; model_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 32'({data_out, data_valid, busy, frame_err, parity_err, overrun}), 32'd0);
    rst = 1'b0;
    step();

    // 0xA5, strobe every 4th cycle, then hold and release
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 4, "a5");
    check("a5_word", 32'(data_out), 32'h0A5);
    for (int i = 0; i < 5; i++) begin
      step();
      check("a5_hold", 32'({data_valid, data_out}), 32'h1A5);
    end
    data_ready = 1'b1;
    step();
    check("a5_drained", 32'(data_valid), 32'd0);
    data_ready = 1'b0;

    // framing error
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 4, "3c_ferr");
    pulse_clear("3c");

    // overrun, then accept on the completing edge
    send_frame(8'h11, 1'b1, 1'b1, 1'b0, 2, "11");
    send_frame(8'h22, 1'b1, 1'b1, 1'b0, 2, "22_ovr");
    check("22_keeps_11", 32'(data_out), 32'h11);
    pulse_clear("22");
    send_frame(8'h33, 1'b1, 1'b1, 1'b1, 2, "33_swap");
    data_ready = 1'b0;
    check("33_word", 32'({data_valid, data_out}), 32'h133);

    // reset mid-frame, with a word still held
    strobe(1'b0, 2);
    for (int i = 0; i < 4; i++) strobe(1'b1, 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_valid = 1'b0;
    model_data  = '0;
    check("rst_mid_outputs", 32'({data_out, data_valid, busy, frame_err, parity_err, overrun}), 32'd0);
    send_frame(8'h5A, 1'b1, 1'b1, 1'b0, 3, "5a_after_rst");
    data_ready = 1'b1;
    step();
    data_ready = 1'b0;

`ifdef SIPO_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1, 1'b0, 2, "07_par_ok");
    data_ready = 1'b1;
    step();
    data_ready = 1'b0;
    send_frame(8'h07, 1'b1, 1'b0, 1'b0, 2, "07_par_bad");
    pulse_clear("07");
`endif

    // continuous bit_en, back-to-back frames, ready tied high
    data_ready = 1'b1;
    send_frame(8'h01, 1'b1, 1'b1, 1'b1, 1, "b2b_01");
    send_frame(8'h80, 1'b1, 1'b1, 1'b1, 1, "b2b_80");
    step();
    check("b2b_drained", 32'(data_valid), 32'd0);
    data_ready = 1'b0;

    // randomized frames
    for (int n = 0; n < 40; n++) begin
      rd = DATA_W'($urandom);
      data_ready = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 2)) step();
      send_frame(rd, 1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 5) != 0),
                 1'($urandom_range(0, 1)), int'($urandom_range(1, 4)), $sformatf("rnd%0d", n));
    end
    pulse_clear("rnd_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sipo_frame_rx.md
# sipo_frame_rx

- Framed serial receiver that sits directly downstream of the sampling DFF in the SIPO shift-register path.
- Consumes the registered serial bit stream one bit per `bit_en` strobe, detects a start bit and shifts in `DATA_W` data bits LSB-first.
- Checks the stop bit, then presents the assembled word on a valid/ready parallel interface with overrun and framing-error reporting.

## Interface
- `DATA_W`, 8: data bits per frame; legal range 2..32.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `serial_in` input 1: registered serial bit from the upstream DFF; idle level 1.
- `bit_en` input 1: one-cycle strobe, one per bit period; the receiver samples `serial_in` only when it is high.
- `data_out` output DATA_W: last accepted frame payload; bit 0 is the first data bit received.
- `data_valid` output 1: `data_out` holds an unconsumed word.
- `data_ready` input 1: consumer accepts the word on an edge where `data_valid & data_ready`.
- `busy` output 1: high in any state other than IDLE.
- `frame_err` output 1: one-cycle pulse when the stop bit is sampled as 0.
- `parity_err` output 1: one-cycle pulse on parity mismatch; tied 0 when parity is compiled out.
- `overrun` output 1: one-cycle pulse when a good frame completes while `data_valid` is still held.

## Operation
- FSM states: IDLE, DATA, PARITY (present only with the macro), STOP.
- All transitions happen on edges where `bit_en`=1.
- **IDLE:** `serial_in`=0 moves to DATA and clears the bit counter. `serial_in`=1 stays in IDLE.
- **DATA:** each strobe does `shreg <= {serial_in, shreg[DATA_W-1:1]}` and increments the counter.
  - The counter is `$clog2(DATA_W+1)` bits wide.
  - After the strobe that captures bit `DATA_W-1`, move to PARITY if compiled in, otherwise STOP.
- **PARITY:** sample the parity bit, latch the mismatch result, go to STOP.
- **STOP:** sample `serial_in`, then return to IDLE. Outcomes in order of precedence:
  - `serial_in`=0: pulse `frame_err`, discard the word.
  - Parity mismatch: pulse `parity_err`, discard the word.
  - `data_valid`=0, or being accepted on the same edge: load `data_out <= shreg`, set `data_valid`.
  - `data_valid`=1 and not being accepted: pulse `overrun`, drop the new word, keep the old word.
- **Handshake:**
  - `data_valid` stays high until an edge with `data_ready`=1; it clears on that edge unless a new word loads on the same edge.
  - `data_out` is stable while `data_valid`=1.
- `bit_en` low: the FSM, counter and `shreg` hold. The handshake is still evaluated every cycle.
- Strobes arriving in IDLE with `serial_in`=1 are ignored, so back-to-back frames are allowed with no idle gap.

## Timing
- Reset values: `data_out`=0, `data_valid`=0, `busy`=0, `frame_err`=0, `parity_err`=0, `overrun`=0. State=IDLE, counter=0, `shreg`=0.
- `rst` asserted mid-frame aborts the frame on that edge; no error pulse is produced and any held word is lost.
- `rst` has priority over all other inputs.
- Latency: `data_valid` rises on the same edge that samples the stop bit, so it is visible in the following cycle.
- Error and overrun pulses are registered on the stop-bit edge and last exactly one clock.
- `busy` rises on the edge that samples the start bit and falls on the stop-bit edge.
- Frame length in strobes: 1 start + `DATA_W` data + 1 stop, plus 1 parity strobe with the macro.
- Continuous `bit_en` (every cycle) must be supported.

## Configuration
- `SIPO_RX_PARITY_EN`
  - Defined: adds the PARITY state and one even-parity bit between the last data bit and the stop bit. The bit is valid when the XOR of data and parity equals 0; a mismatch pulses `parity_err` and drops the word.
  - Undefined: no PARITY state, and `parity_err` is constant 0.

## Test plan
- Reset, then send 0xA5 with `DATA_W`=8 and `bit_en` every 4th cycle. Bits after start: 1,0,1,0,0,1,0,1, stop 1. Expect `data_out`=8'hA5 and `data_valid`=1 the cycle after the stop-bit edge. Hold `data_ready`=0 for 5 cycles: word stable. Then `data_ready`=1: `data_valid` clears next cycle.
- Send 0x3C with the stop bit at 0. Expect a single-cycle `frame_err`, `data_valid` stays 0, and `busy` falls.
- Send 0x11 and leave it unread, then send 0x22. Expect `overrun` pulse, `data_out` still 8'h11. Assert `data_ready` on the edge that completes a third frame 0x33: `data_out`=8'h33, `data_valid` stays 1, no `overrun`.
- Assert `rst` for one cycle after 4 data bits of 0xFF. Expect IDLE and all outputs 0. A following frame 0x5A is received correctly.
- With `SIPO_RX_PARITY_EN` defined, send 0x07 with parity 1: word delivered. Send 0x07 with parity 0: `parity_err` pulses for one cycle and `data_valid`=0.
- Continuous `bit_en` with back-to-back frames 0x01, 0x80, no idle gap, `data_ready` tied 1. Both words are delivered in order with no errors.
